// File: rtl/imm_decode_stage.sv
// ----------------------------------------------------------------------------
// imm_decode_stage
//
// Registered, handshaked immediate-decode stage that sits between fetch and
// execute. For every RV32I/RV64I format it recovers the immediate,
// sign-extends it to XLEN and tags the format. inst/pc pass through a
// one-cycle output register backed by a one-entry skid buffer. in_ready is a
// register, so upstream never sees a combinational path from out_ready.
//
// Parameters
//   XLEN        32 or 64; width of pc and imm
//
// Ports
//   clk         clock, all state on rising edge
//   rst         synchronous reset, active-high
//   flush       drop every held entry (branch redirect)
//   in_valid    upstream offers in_inst/in_pc
//   in_ready    stage accepts this cycle (registered)
//   in_inst     instruction word
//   in_pc       instruction address
//   out_valid   out_* hold a decoded entry
//   out_ready   downstream consumes this cycle
//   out_inst    instruction, passed through
//   out_pc      pc, passed through
//   out_imm     decoded immediate
//   out_fmt     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
//   out_illegal (only with IMM_DECODE_ILLEGAL_EN) entry failed decode checks
//
// Build option
//   IMM_DECODE_ILLEGAL_EN  adds out_illegal and the checking logic behind it.
//
// Occupancy FSM
//   state | meaning
//   EMPTY | nothing held, out_valid=0
//   ONE   | one entry in the output register
//   FULL  | output register and skid both held, in_ready=0
// ----------------------------------------------------------------------------
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt
`ifdef IMM_DECODE_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Decode. Every format is first built as a 32-bit signed value and then
    // widened once; SHAMT values have bit 31 clear so widening zero-extends.
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [31:0]     dec_imm32;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        dec_imm32 = 32'd0;
        dec_fmt   = FMT_NONE;
        case (opcode)
            OP_IMM: begin
                if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    if (XLEN == 64) dec_imm32 = {26'd0, in_inst[25:20]};
                    else            dec_imm32 = {27'd0, in_inst[24:20]};
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    if (is_shift) begin
                        dec_fmt   = FMT_SHAMT;
                        dec_imm32 = {27'd0, in_inst[24:20]};
                    end else begin
                        dec_fmt   = FMT_I;
                        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    end
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OP_STORE: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {in_inst[31:12], 12'd0};
            end
            OP_JAL: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0};
            end
            default: begin
                dec_fmt   = FMT_NONE;
                dec_imm32 = 32'd0;
            end
        endcase
    end

    assign dec_imm = XLEN'($signed(dec_imm32));

`ifdef IMM_DECODE_ILLEGAL_EN
    // On RV64 OP-IMM the shamt borrows inst[25], so only the upper six
    // funct bits are checked there.
    logic dec_funct_ok;
    logic dec_illegal;

    always_comb begin
        if ((XLEN == 64) && (opcode == OP_IMM))
            dec_funct_ok = (in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000);
        else
            dec_funct_ok = (in_inst[31:25] == 7'b0000000) || (in_inst[31:25] == 7'b0100000);
    end

    assign dec_illegal = (dec_fmt == FMT_NONE)
                      || ((dec_fmt == FMT_SHAMT) && (XLEN == 32) && in_inst[25])
                      || ((dec_fmt == FMT_SHAMT) && !dec_funct_ok);

    logic skid_illegal;
`endif

    // ------------------------------------------------------------------
    // Pipeline register, skid buffer and occupancy FSM
    // ------------------------------------------------------------------
    logic [31:0]     skid_inst;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;

    logic accept;
    logic retire;

    assign accept = in_valid && in_ready;
    assign retire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
            out_imm   <= '0;
            out_fmt   <= FMT_NONE;
            skid_inst <= '0;
            skid_pc   <= '0;
            skid_imm  <= '0;
            skid_fmt  <= FMT_NONE;
`ifdef IMM_DECODE_ILLEGAL_EN
            out_illegal  <= 1'b0;
            skid_illegal <= 1'b0;
`endif
        end else if (flush) begin
            // Held data is left in place; out_valid=0 is what kills it.
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_inst  <= in_inst;
                        out_pc    <= in_pc;
                        out_imm   <= dec_imm;
                        out_fmt   <= dec_fmt;
`ifdef IMM_DECODE_ILLEGAL_EN
                        out_illegal <= dec_illegal;
`endif
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !retire) begin
                        skid_inst <= in_inst;
                        skid_pc   <= in_pc;
                        skid_imm  <= dec_imm;
                        skid_fmt  <= dec_fmt;
`ifdef IMM_DECODE_ILLEGAL_EN
                        skid_illegal <= dec_illegal;
`endif
                        in_ready  <= 1'b0;
                        state     <= ST_FULL;
                    end else if (accept && retire) begin
                        out_inst  <= in_inst;
                        out_pc    <= in_pc;
                        out_imm   <= dec_imm;
                        out_fmt   <= dec_fmt;
`ifdef IMM_DECODE_ILLEGAL_EN
                        out_illegal <= dec_illegal;
`endif
                    end else if (retire) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (retire) begin
                        out_inst  <= skid_inst;
                        out_pc    <= skid_pc;
                        out_imm   <= skid_imm;
                        out_fmt   <= skid_fmt;
`ifdef IMM_DECODE_ILLEGAL_EN
                        out_illegal <= skid_illegal;
`endif
                        in_ready  <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
